// File: rtl/mu0_arb_mux_if.sv
// Handshake bundle for the MU0 arbitrating mux: the request side (CHANNELS
// packed valid/ready word sources plus the arbitration mode) and the single
// registered output side towards the shared consumer.
interface mu0_arb_mux_if #(
    parameter int WIDTH     = 12,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_WIDTH-1:0]      out_sel;
    logic                      out_valid;
    logic                      out_ready;

    // Producers of words and the consumer of the merged stream
    modport master (
        output in_data,
        output in_valid,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

    // The arbitrating mux itself
    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );
endinterface

// File: rtl/mu0_arb_mux.sv
// MU0 arbitrating mux: picks one of CHANNELS valid/ready sources per cycle
// (fixed priority or round-robin, selectable every cycle) and forwards the
// winning word into a one-entry output register with its channel index.
module mu0_arb_mux #(
    parameter int WIDTH     = 12,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    mu0_arb_mux_if.slave  bus
);

    // Index space padded to a power of two so any SEL_WIDTH index is legal;
    // the padding slots never request, so they can never win.
    localparam int SLOTS = 1 << SEL_WIDTH;
    // One extra bit so last_grant + k (k <= CHANNELS) cannot overflow.
    localparam int IDX_W = SEL_WIDTH + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [WIDTH-1:0]     out_data_reg;
    logic [SEL_WIDTH-1:0] out_sel_reg;
    logic [SEL_WIDTH-1:0] last_grant_reg;

    logic                 out_valid;
    logic                 load;
    logic                 any_valid;
    logic                 grant_en;
    logic                 take;
    logic [SEL_WIDTH-1:0] fp_idx;
    logic [SEL_WIDTH-1:0] rr_idx;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [SLOTS-1:0]     valid_pad;
    logic [WIDTH-1:0]     chan_data [SLOTS];

    // Unpack channel words and requests into the padded index space
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_real
                assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
                assign valid_pad[gi] = bus.in_valid[gi];
            end else begin : g_pad
                assign chan_data[gi] = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // The output register can take a word when empty or being drained now
    assign load      = !out_valid || bus.out_ready;
    assign any_valid = |bus.in_valid;

    // Fixed priority: scanning downwards leaves the lowest requester last
    always_comb begin
        fp_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (valid_pad[i]) begin
                fp_idx = SEL_WIDTH'(i);
            end
        end
    end

    // Round-robin: scan offsets from furthest to nearest after last_grant,
    // so the first requester in search order is the one that sticks
    always_comb begin
        logic [IDX_W-1:0] cand;
        rr_idx = '0;
        cand   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            cand = {1'b0, last_grant_reg} + IDX_W'(k);
            if (cand >= IDX_W'(CHANNELS)) begin
                cand = cand - IDX_W'(CHANNELS);
            end
            if (valid_pad[cand[SEL_WIDTH-1:0]]) begin
                rr_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    // Grant is suppressed during reset so no same-cycle handshake can happen
    assign grant_idx = bus.mode ? rr_idx : fp_idx;
    assign grant_en  = load && any_valid && !reset;

    // One-hot ready towards the winning channel only
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign bus.in_ready[gi] = grant_en && (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    assign take = |(bus.in_valid & bus.in_ready);

    // Output stage state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output stage next state: a transfer always fills, a bare drain empties
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (take) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (take) begin
                    state_next = ST_FULL;
                end else if (bus.out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Output stage outputs: valid is simply the FULL state
    always_comb begin
        out_valid = (state_reg == ST_FULL);
    end

    // Word/index capture and round-robin pointer; everything holds unless a
    // transfer happens, so back-pressure and drain leave them untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg   <= '0;
            out_sel_reg    <= '0;
            last_grant_reg <= SEL_WIDTH'(CHANNELS - 1);
        end else if (take) begin
            out_data_reg   <= chan_data[grant_idx];
            out_sel_reg    <= grant_idx;
            last_grant_reg <= grant_idx;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;

endmodule
